// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: owns the fetch PC and drives a single-outstanding SRAM-like bus.
// Optional feature macro FETCH_ADEL_EN: misaligned fetch PCs become address-error slots.
`timescale 1ns/1ps
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_stall,
    input  logic        if_id_refresh,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    typedef enum logic [1:0] {StRun, StAddr, StData} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        cancel_q, cancel_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        slot_free;
    logic        misaligned;
    logic        fill;

    assign redirect        = if_id_refresh | br_taken;
    assign redirect_target = if_id_refresh ? redirect_pc : br_target;
    assign slot_free       = ~valid_q | ~if_id_stall;

`ifdef FETCH_ADEL_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        cancel_d   = cancel_q;
        req_d      = req_q;
        valid_d    = valid_q;
        adel_d     = adel_q;
        fill       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (!redirect && slot_free) begin
                    if (misaligned) begin
                        // Report the bad PC in place of an instruction; no bus access.
                        fill       = 1'b1;
                        out_pc_d   = pc_q;
                        out_inst_d = 32'h0;
                        adel_d     = 1'b1;
                    end else begin
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        req_d      = 1'b1;
                        state_d    = StAddr;
                    end
                end
            end
            StAddr: begin
                // The request stays up until accepted; a redirect only marks it stale.
                if (inst_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = StData;
                end
                if (redirect) begin
                    cancel_d = 1'b1;
                end
            end
            StData: begin
                if (inst_data_ok) begin
                    state_d  = StRun;
                    cancel_d = 1'b0;
                    if (!cancel_q && !redirect && !(valid_q && if_id_stall)) begin
                        fill       = 1'b1;
                        out_pc_d   = req_addr_q;
                        out_inst_d = inst_rdata;
                        adel_d     = 1'b0;
                    end
                end else if (redirect) begin
                    cancel_d = 1'b1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (redirect) begin
            pc_d    = redirect_target;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (fill) begin
            valid_d = 1'b1;
        end else if (!if_id_stall) begin
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            out_pc_q   <= 32'h0;
            out_inst_q <= 32'h0;
            cancel_q   <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            cancel_q   <= cancel_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            adel_q     <= adel_d;
        end
    end

    assign inst_req  = req_q;
    assign inst_addr = req_addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = out_pc_q;
    assign if_inst   = out_inst_q;
    assign if_adel   = adel_q;

    // Issue only happens into a free slot, so a live delivery never meets a stalled full slot.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == StData && inst_data_ok && !cancel_q && !redirect)
            |-> !(valid_q && if_id_stall));

endmodule
